demux_stream_nch: RTL and testbench
===================================

Name: demux_stream_nch

Overview:
Parametrised, registered 1-to-N stream demultiplexer. It is the successor to the 8-output combinational demux. It routes beats from one valid/ready input stream to one of NUM_CH output channels. Each channel has a one-deep holding register, so a stalled channel blocks only beats addressed to it. Target selection is either by explicit address or by an internal round-robin pointer. The block sits between a single producer and NUM_CH independent consumers.

Parameters:
NUM_CH, 8, number of output channels (2..64; need not be a power of two)
DW, 8, data width per beat
AW, $clog2(NUM_CH), address width (derived, not overridable)
CW, 16, width of the accepted-beat counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
sel  in  1  global enable; 0 = accept nothing, drain only
mode  in  1  0 = addressed, 1 = round-robin
addr  in  AW  target channel in addressed mode
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DW  input beat data
out_valid  out  NUM_CH  per-channel holding register full
out_ready  in  NUM_CH  per-channel consumer ready
out_data  out  NUM_CH*DW  channel k occupies bits [k*DW +: DW]
cur_ch  out  AW  target channel for the current cycle
err  out  1  one-cycle pulse: the previous accepted beat had an out-of-range address
beat_cnt  out  CW  count of accepted beats, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, rr pointer=0, err=0, beat_cnt=0.
  - Reset mid-transfer discards all buffered beats.
  - in_ready is 0 while rst is high.
- Target selection: cur_ch = (mode==0) ? addr : rr_ptr. It is combinational and has no clock latency.
- Range check: range_ok = (cur_ch < NUM_CH). It is always true when NUM_CH is a power of two.
- Ready:
  - in_ready = sel && !rst && (!range_ok || !out_valid[cur_ch] || out_ready[cur_ch]).
  - Pass-through is allowed: a full channel being drained in the same cycle accepts a new beat.
- Accept (in_valid && in_ready at clk edge):
  - range_ok=1: out_data[cur_ch] <= in_data and out_valid[cur_ch] <= 1. The beat is visible on the output next cycle (latency 1).
  - range_ok=0: the beat is consumed and dropped, and err=1 on the next cycle.
  - beat_cnt increments on every accepted beat, dropped beats included. It saturates at 2^CW-1 and does not wrap.
- Drain: out_valid[k] && out_ready[k] clears out_valid[k] unless channel k is reloaded in the same cycle; reload wins, so valid stays 1 with the new data.
- out_data[k] holds its value while out_valid[k]=1. Its value when out_valid[k]=0 is don't-care but must be stable: no update without an accept.
- Round-robin:
  - rr_ptr advances only on an accepted beat while mode=1.
  - It wraps from NUM_CH-1 to 0.
  - It holds while mode=0, while sel=0, or while stalled.
  - If the target channel is full and not draining, in_ready=0 and rr_ptr does not skip ahead (strict order).
- sel=0: no accepts and rr_ptr frozen. Channels continue to drain normally.
- Mode switch takes effect in the same cycle. rr_ptr keeps its value across switches.
- Channel states: each channel is EMPTY/FULL (1 bit).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on hold, or on drain+load.
- All outputs except in_ready and cur_ch are registered.

Decomposition:
- Package demux_stream_pkg holds:
  - MODE_ADDR=1'b0 and MODE_RR=1'b1 constants.
  - A localparam helper for AW.
  - The saturating-increment function used for beat_cnt.
- Sub-module demux_ch_buf: a one-deep valid/ready register with inputs clk, rst, load, load_data, out_ready and outputs out_valid, out_data. It is instantiated NUM_CH times in a generate loop.
- The top level holds target selection, in_ready, rr_ptr, err and beat_cnt.

Test Plan:
1. rst=1 for 2 cycles with in_valid=1, then release with sel=0 -> out_valid=8'h00, in_ready=0, beat_cnt=0 throughout.
2. mode=0, sel=1, out_ready=8'hFF, addr=3'b101, in_data=8'hA5, 1 beat -> next cycle out_valid=8'h20, out_data[47:40]=8'hA5, beat_cnt=1.
3. mode=0, out_ready[2]=0, two beats to addr=2 (8'h11 then 8'h22) -> first accepted; second stalls with in_ready=0 and channel 2 holds 8'h11. Raise out_ready[2] -> 8'h22 accepted in that same cycle, out_valid[2] stays 1.
4. mode=1, out_ready=8'hFF, 10 consecutive beats 8'h00..8'h09 -> channels 0..7 receive 00..07, then channel 0 gets 08 and channel 1 gets 09. cur_ch wraps 7->0, beat_cnt=10.
5. NUM_CH=5, mode=0, addr=3'b110, one beat 8'h3C -> accepted, out_valid unchanged, err=1 for exactly one cycle, beat_cnt increments.
6. mode=1 streaming with out_ready=8'hFF, assert rst mid-stream after channel 3 is loaded -> next cycle out_valid=0, rr_ptr=0, beat_cnt=0; the first beat after release goes to channel 0.

Source files
------------

// File: rtl/demux_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_stream_pkg                                                   |
// | Shared constants, channel state type and helpers for the demux.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package demux_stream_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    typedef enum logic [0:0] {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    // Address width for a channel count; never narrower than one bit.
    function automatic int calc_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v == max_v) ? v : (v + 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_ch_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_ch_buf                                                       |
// | One-deep valid/ready holding register for a single output channel.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux_ch_buf
    import demux_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    ch_state_t     r_state;
    ch_state_t     w_state_next;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CH_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (load) begin
                r_data <= load_data;
            end
        end
    end

    // A load in the drain cycle keeps the channel full with the new beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CH_EMPTY: if (load) w_state_next = CH_FULL;
            CH_FULL:  if (out_ready && !load) w_state_next = CH_EMPTY;
            default:  w_state_next = CH_EMPTY;
        endcase
    end

    assign out_valid = (r_state == CH_FULL);
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_stream_nch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_stream_nch                                                   |
// | Registered 1-to-N valid/ready demux, addressed or round-robin.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux_stream_nch
    import demux_stream_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int DW     = 8,
    parameter  int CW     = 16,
    localparam int AW     = calc_aw(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic                 mode,
    input  logic [AW-1:0]        addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [AW-1:0]        cur_ch,
    output logic                 err,
    output logic [CW-1:0]        beat_cnt
);

    localparam logic [AW:0]   c_num_ch  = (AW+1)'(NUM_CH);
    localparam logic [AW-1:0] c_last_ch = AW'(NUM_CH - 1);

    logic [AW-1:0]     r_rr_ptr;
    logic              r_err;
    logic [CW-1:0]     r_beat_cnt;
    logic [AW-1:0]     w_cur_ch;
    logic              w_range_ok;
    logic              w_tgt_full;
    logic              w_tgt_rdy;
    logic              w_accept;
    logic [NUM_CH-1:0] w_load;

    assign w_cur_ch   = (mode == MODE_ADDR) ? addr : r_rr_ptr;
    assign w_range_ok = ({1'b0, w_cur_ch} < c_num_ch);

    // Explicit scan avoids indexing past NUM_CH for out-of-range addresses.
    always_comb begin
        w_tgt_full = 1'b0;
        w_tgt_rdy  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_cur_ch == AW'(k)) begin
                w_tgt_full = out_valid[k];
                w_tgt_rdy  = out_ready[k];
            end
        end
    end

    assign in_ready = sel && !rst && (!w_range_ok || !w_tgt_full || w_tgt_rdy);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_err <= w_accept && !w_range_ok;
            if (w_accept) begin
                r_beat_cnt <= CW'(sat_inc(64'(r_beat_cnt), CW));
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (r_rr_ptr == c_last_ch) ? '0 : r_rr_ptr + AW'(1);
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign w_load[k] = w_accept && w_range_ok && (w_cur_ch == AW'(k));

            demux_ch_buf #(
                .DW(DW)
            ) u_buf (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[k]),
                .load_data (in_data),
                .out_ready (out_ready[k]),
                .out_valid (out_valid[k]),
                .out_data  (out_data[k*DW +: DW])
            );
        end
    endgenerate

    assign cur_ch   = w_cur_ch;
    assign err      = r_err;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_nch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux_stream_nch                                                |
// | Scoreboard bench for demux_stream_nch (8-channel and 5-channel).   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_demux_stream_nch;

    logic        clk = 1'b0;
    logic        rst, sel, mode, in_valid, in_valid5;
    logic [2:0]  addr;
    logic [7:0]  in_data;
    logic [7:0]  out_ready;
    logic        in_ready, in_ready5, err, err5;
    logic [7:0]  out_valid;
    logic [4:0]  out_valid5;
    logic [63:0] out_data;
    logic [39:0] out_data5;
    logic [2:0]  cur_ch, cur_ch5;
    logic [15:0] beat_cnt, beat_cnt5;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[8][$];
    logic [2:0] rr_m = 3'd0;
    int         cnt_m = 0;
    logic [2:0] last_ch;

    always #5 clk = ~clk;

    demux_stream_nch #(.NUM_CH(8), .DW(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .addr(addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_ch(cur_ch), .err(err), .beat_cnt(beat_cnt)
    );

    demux_stream_nch #(.NUM_CH(5), .DW(8), .CW(16)) u_dut5 (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .addr(addr),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data),
        .out_valid(out_valid5), .out_ready(5'h1F), .out_data(out_data5),
        .cur_ch(cur_ch5), .err(err5), .beat_cnt(beat_cnt5)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic note_accept(input logic [2:0] ch, input logic [7:0] d);
        exp_q[ch].push_back(d);
        cnt_m++;
        last_ch = ch;
    endtask

    // Drive one beat on the 8-channel DUT; returns #1 after the accepting edge.
    task automatic send_beat(input logic m, input logic [2:0] a, input logic [7:0] d);
        logic [2:0] ch;
        bit done;
        done = 0;
        mode = m; addr = a; in_data = d; in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ch = m ? rr_m : a;
                chk("cur_ch", cur_ch, ch);
                note_accept(ch, d);
                if (m) rr_m = (rr_m == 3'd7) ? 3'd0 : rr_m + 3'd1;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Consumer side: every completed handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    chk($sformatf("q_nonempty%0d", k), 64'(exp_q[k].size() != 0), 1);
                    if (exp_q[k].size() != 0)
                        chk($sformatf("ch%0d_data", k), out_data[k*8 +: 8], exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        rst = 1; sel = 1; mode = 0; addr = 0; in_data = 0; in_valid = 1;
        in_valid5 = 0; out_ready = 8'hFF;

        // Reset with valid asserted, then release with sel low
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 8'h00);
            chk("rst_beat_cnt", beat_cnt, 0);
        end
        @(posedge clk); #1; rst = 0; sel = 0;
        repeat (2) begin
            @(negedge clk);
            chk("sel0_in_ready", in_ready, 0);
            chk("sel0_out_valid", out_valid, 8'h00);
            chk("sel0_beat_cnt", beat_cnt, 0);
            @(posedge clk); #1;
        end
        in_valid = 0; sel = 1;

        // Addressed single beat
        send_beat(0, 3'd5, 8'hA5);
        @(negedge clk);
        chk("addr_out_valid", out_valid, 8'h20);
        chk("addr_out_data", out_data[47:40], 8'hA5);
        chk("addr_beat_cnt", beat_cnt, 64'(cnt_m));
        chk("addr_err", err, 0);
        @(posedge clk); #1;

        // Stall on channel 2, then pass-through when it drains
        out_ready = 8'hFB;
        send_beat(0, 3'd2, 8'h11);
        addr = 3'd2; in_data = 8'h22; in_valid = 1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold", out_data[23:16], 8'h11);
            chk("stall_valid", out_valid[2], 1);
            @(posedge clk); #1;
        end
        out_ready = 8'hFF;
        @(negedge clk);
        chk("pass_in_ready", in_ready, 1);
        note_accept(3'd2, 8'h22);
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk);
        chk("pass_valid", out_valid[2], 1);
        chk("pass_data", out_data[23:16], 8'h22);
        chk("pass_beat_cnt", beat_cnt, 64'(cnt_m));
        @(posedge clk); #1;

        // Round-robin streaming with wrap
        for (int i = 0; i < 10; i++) send_beat(1, 3'd0, 8'(i));
        @(negedge clk);
        chk("rr_beat_cnt", beat_cnt, 64'(cnt_m));
        chk("rr_cur_ch", cur_ch, 3'd2);
        @(posedge clk); #1;

        // Out-of-range address on the 5-channel instance
        mode = 0; addr = 3'd6; in_data = 8'h3C; in_valid5 = 1;
        @(negedge clk);
        chk("oor_in_ready", in_ready5, 1);
        @(posedge clk); #1; in_valid5 = 0;
        @(negedge clk);
        chk("oor_err", err5, 1);
        chk("oor_out_valid", out_valid5, 5'h00);
        chk("oor_beat_cnt", beat_cnt5, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("oor_err_pulse", err5, 0);
        @(posedge clk); #1;
        addr = 3'd4; in_data = 8'h5A; in_valid5 = 1;
        @(negedge clk);
        chk("ir_in_ready", in_ready5, 1);
        @(posedge clk); #1; in_valid5 = 0;
        @(negedge clk);
        chk("ir_out_valid", out_valid5, 5'h10);
        chk("ir_out_data", out_data5[39:32], 8'h5A);
        chk("ir_err", err5, 0);
        chk("ir_beat_cnt", beat_cnt5, 2);
        chk("u8_err", err, 0);
        @(posedge clk); #1;

        // Reset mid-stream discards buffered beats and rewinds the pointer
        out_ready = 8'h00;
        last_ch = 3'd7;
        for (int n = 0; n < 8 && last_ch != 3'd3; n++) send_beat(1, 3'd0, 8'h60 + 8'(n));
        rst = 1;
        @(negedge clk);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_out_valid", out_valid, 8'h0C);
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        rr_m = 3'd0; cnt_m = 0;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 8'h00);
        chk("post_rst_cnt", beat_cnt, 0);
        chk("post_rst_cur_ch", cur_ch, 3'd0);
        @(posedge clk); #1;
        out_ready = 8'hFF;
        send_beat(1, 3'd0, 8'h77);
        @(negedge clk);
        chk("post_rst_first", out_valid, 8'h01);
        chk("post_rst_cnt1", beat_cnt, 1);
        @(posedge clk); #1;
        @(negedge clk);

        total = 0;
        for (int k = 0; k < 8; k++) total += exp_q[k].size();
        chk("queues_empty", 64'(total), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
